// File: rtl/ula_arb.sv
// ---------------------------------------------------------------------------
// ula_arb -- round-robin scheduler sharing one ula_fx ALU among NREQ requesters.
//
// One operation is in flight at a time. A granted request has its opcode and
// operands registered onto the ALU inputs. They are held for one EXEC cycle,
// or for DIV_CYC cycles for DIV (4) and MOD (5), so that the combinational
// divider can be constrained as a multicycle path. The ALU result is then
// captured and returned, tagged with the requester index, on a single
// response channel that supports backpressure.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   req_valid  in   [NREQ]         per-requester request valid
//   req_ready  out  [NREQ]         one-hot grant (only in IDLE, never in reset)
//   req_op     in   [5*NREQ]       packed opcodes, requester k at [5k+4:5k]
//   req_in1    in   [NUBITS*NREQ]  packed operand 1, slice k at [NUBITS*k +: NUBITS]
//   req_in2    in   [NUBITS*NREQ]  packed operand 2, same packing
//   alu_op     out  [5]            registered opcode to ula_fx.op
//   alu_in1    out  [NUBITS]       registered operand to ula_fx.in1
//   alu_in2    out  [NUBITS]       registered operand to ula_fx.in2
//   alu_out    in   [NUBITS]       ula_fx.out
//   rsp_valid  out                 result valid
//   rsp_ready  in                  consumer accepts result
//   rsp_data   out  [NUBITS]       captured ALU result
//   rsp_id     out  [IDW]          requester that owns rsp_data
//   busy       out                 high in EXEC and RESP
// ---------------------------------------------------------------------------
module ula_arb #(
  parameter int NUBITS  = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DIV_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [5*NREQ-1:0]      req_op,
  input  logic [NUBITS*NREQ-1:0] req_in1,
  input  logic [NUBITS*NREQ-1:0] req_in2,
  output logic [4:0]             alu_op,
  output logic [NUBITS-1:0]      alu_in1,
  output logic [NUBITS-1:0]      alu_in2,
  input  logic [NUBITS-1:0]      alu_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NUBITS-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  localparam int              CNT_W    = (DIV_CYC > 1) ? $clog2(DIV_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(DIV_CYC - 1);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     cur_id;
  logic [CNT_W-1:0]   cnt;
  logic               pick_vld;
  logic [IDW-1:0]     pick_id;
  logic               take;
  logic               done;
  logic               rsp_take;
  logic [4:0]         op_p0;
  logic [NUBITS-1:0]  in1_p0;
  logic [NUBITS-1:0]  in2_p0;

  // DIV and MOD go through the slow divider and get the long hold.
  function automatic logic is_long_op(input logic [4:0] op);
    return (op == 5'd4) || (op == 5'd5);
  endfunction

  // Successor index modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id == LAST_ID) ? '0 : id + IDW'(1);
  endfunction

  // Rotating search: first valid requester at or after ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] cand;
    pick_vld = 1'b0;
    pick_id  = ptr;
    cand     = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
      cand = next_id(cand);
    end
  end

  // Next-state and strobes.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    rsp_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          take      = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_take  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is combinational and suppressed while reset is asserted so no
  // requester believes it was accepted on a reset edge.
  assign req_ready = (take && !rst) ? (NREQ'(1) << pick_id) : '0;

  // Stage p0: operand selection for the granted requester.
  assign op_p0  = req_op[5*pick_id +: 5];
  assign in1_p0 = req_in1[NUBITS*pick_id +: NUBITS];
  assign in2_p0 = req_in2[NUBITS*pick_id +: NUBITS];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  // Stage p0 -> ALU inputs: registered on transfer, held until next transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      cur_id  <= '0;
      cnt     <= '0;
      alu_op  <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
    end else if (take) begin
      alu_op  <= op_p0;
      alu_in1 <= in1_p0;
      alu_in2 <= in2_p0;
      cur_id  <= pick_id;
      ptr     <= next_id(pick_id);
      cnt     <= is_long_op(op_p0) ? CNT_LONG : '0;
    end else if (state == EXEC && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ALU output -> response register: captured on the last EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_out;
      rsp_id    <= cur_id;
    end else if (rsp_take) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ula_arb.sv
module tb_ula_arb;

  localparam int NUBITS  = 32;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int DIV_CYC = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [5*NREQ-1:0]      req_op;
  logic [NUBITS*NREQ-1:0] req_in1;
  logic [NUBITS*NREQ-1:0] req_in2;
  logic [4:0]             alu_op;
  logic [NUBITS-1:0]      alu_in1;
  logic [NUBITS-1:0]      alu_in2;
  logic [NUBITS-1:0]      alu_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [NUBITS-1:0]      rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   busy;

  always #5 clk = ~clk;

  ula_arb #(.NUBITS(NUBITS), .NREQ(NREQ), .IDW(IDW), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Stand-in for ula_fx: a plain combinational ALU.
  function automatic logic [NUBITS-1:0] alu_fn(input logic [4:0] op,
                                               input logic [NUBITS-1:0] a,
                                               input logic [NUBITS-1:0] b);
    case (op)
      5'd0: return '0;
      5'd1: return a;
      5'd2: return a + b;
      5'd3: return a - b;
      5'd4: begin
        if (b == '0) return '1;
        if (b == '1) return '0 - a;
        return $signed(a) / $signed(b);
      end
      5'd5: begin
        if (b == '0) return a;
        if (b == '1) return '0;
        return $signed(a) % $signed(b);
      end
      5'd6: return a & b;
      5'd7: return a | b;
      5'd8: return a ^ b;
      default: return a ^ {b[15:0], b[31:16]} ^ {27'd0, op};
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_in1, alu_in2);

  typedef struct {
    logic [NREQ-1:0]   rr;
    logic              busy;
    logic              rv;
    logic [4:0]        op;
    logic [NUBITS-1:0] a;
    logic [NUBITS-1:0] b;
    logic [NUBITS-1:0] rd;
    logic [IDW-1:0]    rid;
  } snap_t;

  typedef struct {
    logic [NUBITS-1:0] data;
    logic [IDW-1:0]    id;
  } rsp_t;

  snap_t snapq[$];
  rsp_t  rspq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Requester-side stimulus state.
  bit                pend[NREQ];
  logic [4:0]        p_op[NREQ];
  logic [NUBITS-1:0] p_a[NREQ];
  logic [NUBITS-1:0] p_b[NREQ];
  bit                rst_v;
  bit                rrdy;

  // Reference model: one operation owed at a time, response window opens
  // at a computed cycle and closes when the consumer accepts.
  bit                m_owed;
  int                m_rsp_from;
  int                m_ptr;
  logic [4:0]        m_op;
  logic [NUBITS-1:0] m_a, m_b, m_res, m_rd;
  logic [IDW-1:0]    m_id, m_rid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owed = 1'b0; m_rsp_from = 0; m_ptr = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_rd = '0;
    m_id = '0; m_rid = '0;
  endtask

  task automatic post(input int k, input int op, input int a, input int b);
    pend[k] = 1'b1;
    p_op[k] = 5'(op);
    p_a[k]  = a;
    p_b[k]  = b;
  endtask

  // One clock cycle: drive inputs just after the edge, then predict what the
  // DUT must show during this cycle and what the coming edge does.
  task automatic step();
    snap_t s;
    rsp_t  r;
    int    k;
    int    len;
    @(posedge clk);
    #1;
    rst       = rst_v;
    rsp_ready = rrdy;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                  = pend[i];
      req_op[5*i +: 5]              = p_op[i];
      req_in1[NUBITS*i +: NUBITS]   = p_a[i];
      req_in2[NUBITS*i +: NUBITS]   = p_b[i];
    end
    s.rr   = '0;
    s.busy = m_owed;
    s.rv   = m_owed && (cyc >= m_rsp_from);
    s.op   = m_op;
    s.a    = m_a;
    s.b    = m_b;
    s.rd   = s.rv ? m_res : m_rd;
    s.rid  = s.rv ? m_id : m_rid;
    if (rst_v) begin
      if (m_owed) rspq.delete(rspq.size() - 1);
      model_reset();
    end else if (!m_owed) begin
      k = -1;
      for (int d = 0; d < NREQ; d++)
        if (k < 0 && pend[(m_ptr + d) % NREQ]) k = (m_ptr + d) % NREQ;
      if (k >= 0) begin
        s.rr       = NREQ'(1) << k;
        len        = (p_op[k] == 5'd4 || p_op[k] == 5'd5) ? DIV_CYC : 1;
        m_owed     = 1'b1;
        m_rsp_from = cyc + 1 + len;
        m_op       = p_op[k];
        m_a        = p_a[k];
        m_b        = p_b[k];
        m_res      = alu_fn(p_op[k], p_a[k], p_b[k]);
        m_id       = IDW'(k);
        m_ptr      = (k + 1) % NREQ;
        pend[k]    = 1'b0;
        r.data     = m_res;
        r.id       = m_id;
        rspq.push_back(r);
      end
    end else if (s.rv && rrdy) begin
      m_owed = 1'b0;
      m_rd   = m_res;
      m_rid  = m_id;
    end
    snapq.push_back(s);
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
  endtask

  // Monitor: compares per-cycle expectations and pops responses as the DUT
  // hands them over.
  always @(negedge clk) begin
    snap_t s;
    rsp_t  r;
    if (snapq.size() > 0) begin
      s = snapq.pop_front();
      chk("req_ready", 64'(req_ready), 64'(s.rr));
      chk("busy",      64'(busy),      64'(s.busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(s.rv));
      chk("alu_op",    64'(alu_op),    64'(s.op));
      chk("alu_in1",   64'(alu_in1),   64'(s.a));
      chk("alu_in2",   64'(alu_in2),   64'(s.b));
      chk("rsp_data",  64'(rsp_data),  64'(s.rd));
      chk("rsp_id",    64'(rsp_id),    64'(s.rid));
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (rspq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", rsp_id, rsp_data);
      end else begin
        r = rspq.pop_front();
        chk("rsp_q_data", 64'(rsp_data), 64'(r.data));
        chk("rsp_q_id",   64'(rsp_id),   64'(r.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; req_valid = '0;
    req_op = '0; req_in1 = '0; req_in2 = '0;
    rst_v = 1'b0; rrdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_op[i] = '0; p_a[i] = '0; p_b[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);

    // Single ADD from requester 0.
    post(0, 2, 5, 7);
    repeat (5) step();

    // All four contend; rotation from requester 0, then 0 again.
    do_reset();
    for (int k = 0; k < NREQ; k++) post(k, 2, k, 100);
    repeat (12) step();
    post(0, 2, 0, 100);
    repeat (6) step();

    // Signed divide with the long hold.
    do_reset();
    post(0, 4, -20, 3);
    repeat (8) step();

    // Backpressure with requester 1 waiting.
    rrdy = 1'b0;
    post(0, 5, -20, 3);
    step();
    post(1, 3, 50, 8);
    repeat (12) step();
    rrdy = 1'b1;
    repeat (6) step();

    // Reset during DIV EXEC, then 0 and 2 contend.
    post(1, 4, 1000, 7);
    repeat (2) step();
    post(0, 2, 11, 22);
    post(2, 2, 33, 44);
    do_reset();
    repeat (8) step();

    // Wrap: requester 3 last, then 0 and 2.
    post(3, 7, 32'h0f0, 32'h00f);
    repeat (3) step();
    post(0, 6, 32'hff, 32'h3c);
    post(2, 8, 32'haa, 32'h55);
    repeat (8) step();

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          int op;
          int b;
          case ($urandom_range(0, 5))
            0: op = 2;
            1: op = 3;
            2: op = 4;
            3: op = 5;
            4: op = int'($urandom_range(6, 8));
            default: op = int'($urandom_range(0, 31));
          endcase
          b = int'($urandom);
          if ($urandom_range(0, 7) == 0) b = 0;
          post(k, op, int'($urandom), b);
        end else if (pend[k] && $urandom_range(0, 29) == 0) begin
          pend[k] = 1'b0;
        end
      end
      rrdy = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain.
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    rrdy = 1'b1;
    repeat (20) step();
    @(negedge clk);
    #1;
    chk("rsp_queue_empty", 64'(rspq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
